sar_ctrl_param: RTL and testbench

Parametrised successive-approximation register (SAR) controller; the next generation of the fixed 4-bit SAR logic. Drives a WIDTH-bit DAC trial code, samples the external comparator once per bit, and publishes the converted result with a one-cycle done pulse. It adds start/abort handshakes, continuous-conversion mode, and optional per-bit DAC settle wait. It sits between the top-level pin wrapper (comparator on a dedicated input, result/done on dedicated outputs) and the analog front end.

---
 rtl/sar_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_sar_ctrl_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl_param.sv
// Parametrised successive-approximation ADC controller with start/abort, continuous mode
// and optional per-bit DAC settle wait (built only when SAR_SETTLE_EN is defined).
module sar_ctrl_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SETTLE_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                cont,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                cmp,
    output logic                sample,
    output logic [WIDTH-1:0]    dac_code,
    output logic [WIDTH-1:0]    result,
    output logic                conv_done,
    output logic                busy
);

    localparam int unsigned     PtrW       = $clog2(WIDTH);
    localparam logic [PtrW-1:0] PtrMsb     = PtrW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FirstTrial = {1'b1, {(WIDTH - 1){1'b0}}};

`ifdef SAR_SETTLE_EN
    typedef enum logic [1:0] {StIdle, StSample, StConv, StSettle} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSample, StConv} state_e;
`endif

    state_e           state_q, state_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] trial;

`ifdef SAR_SETTLE_EN
    logic [SETTLE_W-1:0] s_q, s_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
`else
    logic unused_settle;
    assign unused_settle = ^settle;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        dac_d    = dac_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef SAR_SETTLE_EN
        s_d      = s_q;
        cnt_d    = cnt_q;
`endif

        // Resolve the current bit and raise the next lower one as the new trial.
        trial        = dac_q;
        trial[ptr_q] = cmp;
        if (ptr_q != '0) begin
            trial[ptr_q - 1'b1] = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StSample;
                    dac_d   = '0;
                end
            end
            StSample: begin
                dac_d   = FirstTrial;
                ptr_d   = PtrMsb;
                state_d = StConv;
`ifdef SAR_SETTLE_EN
                s_d = settle;
                if (settle != '0) begin
                    state_d = StSettle;
                    cnt_d   = settle;
                end
`endif
            end
`ifdef SAR_SETTLE_EN
            StSettle: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = StConv;
                end
            end
`endif
            StConv: begin
                if (ptr_q == '0) begin
                    result_d = trial;
                    done_d   = 1'b1;
                    if (cont) begin
                        state_d = StSample;
                        dac_d   = '0;
                    end else begin
                        state_d = StIdle;
                        dac_d   = trial;
                    end
                end else begin
                    dac_d = trial;
                    ptr_d = ptr_q - 1'b1;
`ifdef SAR_SETTLE_EN
                    if (s_q != '0) begin
                        state_d = StSettle;
                        cnt_d   = s_q;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
                dac_d   = '0;
            end
        endcase

        // Abort beats both the decision and continuous restart.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            dac_d    = '0;
            result_d = result_q;
            done_d   = 1'b0;
            ptr_d    = PtrMsb;
`ifdef SAR_SETTLE_EN
            cnt_d    = '0;
`endif
        end

        busy_d   = (state_d != StIdle);
        sample_d = (state_d == StSample);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= PtrMsb;
            dac_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SAR_SETTLE_EN
            s_q      <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef SAR_SETTLE_EN
            s_q      <= s_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign sample    = sample_q;
    assign dac_code  = dac_q;
    assign result    = result_q;
    assign conv_done = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Self-checking bench for sar_ctrl_param: 4-bit and 8-bit instances against a binary-search
// reference model; honours SAR_SETTLE_EN for the expected settle wait.
module tb_sar_ctrl_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] settle;

    logic       start4, abort4, cont4, cmp4, sample4, done4, busy4;
    logic [3:0] dac4, res4;
    logic       start8, abort8, cont8, cmp8, sample8, done8, busy8;
    logic [7:0] dac8, res8;
    int         vin4, vin8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Ideal comparator against the current DAC code.
    assign cmp4 = (vin4 >= int'(dac4));
    assign cmp8 = (vin8 >= int'(dac8));

    sar_ctrl_param #(.WIDTH(4), .SETTLE_W(3)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(abort4), .cont(cont4),
        .settle(settle), .cmp(cmp4), .sample(sample4), .dac_code(dac4), .result(res4),
        .conv_done(done4), .busy(busy4)
    );

    sar_ctrl_param #(.WIDTH(8), .SETTLE_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(abort8), .cont(cont8),
        .settle(settle), .cmp(cmp8), .sample(sample8), .dac_code(dac8), .result(res8),
        .conv_done(done8), .busy(busy8)
    );

    function automatic int eff_s(input int s);
`ifdef SAR_SETTLE_EN
        return s;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] dac_of(input int w);
        return (w == 4) ? 32'(dac4) : 32'(dac8);
    endfunction
    function automatic logic [31:0] res_of(input int w);
        return (w == 4) ? 32'(res4) : 32'(res8);
    endfunction
    function automatic logic [31:0] done_of(input int w);
        return (w == 4) ? 32'(done4) : 32'(done8);
    endfunction
    function automatic logic [31:0] busy_of(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction
    function automatic logic [31:0] sample_of(input int w);
        return (w == 4) ? 32'(sample4) : 32'(sample8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion from IDLE; expected trial codes come from a plain binary search.
    task automatic conv(input int w, input int vin);
        int s;
        int code;
        int trial;
        s = eff_s(int'(settle));
        if (w == 4) begin vin4 = vin; start4 = 1'b1; end
        else begin vin8 = vin; start8 = 1'b1; end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        check("sample_phase", sample_of(w), 1);
        check("sample_dac", dac_of(w), 0);
        check("sample_busy", busy_of(w), 1);
        code = 0;
        for (int b = w - 1; b >= 0; b--) begin
            trial = code | (1 << b);
            for (int k = 0; k <= s; k++) begin
                @(negedge clk);
                check("trial_code", dac_of(w), trial);
                check("no_early_done", done_of(w), 0);
            end
            if (vin >= trial) code = trial;
        end
        @(negedge clk);
        check("done_pulse", done_of(w), 1);
        check("result", res_of(w), code);
        check("idle_busy", busy_of(w), 0);
        check("hold_dac", dac_of(w), code);
        @(negedge clk);
        check("done_single", done_of(w), 0);
        check("result_hold", res_of(w), code);
    endtask

    initial begin
        int last4;
        reset  = 1'b1;
        settle = 3'd0;
        {start4, abort4, cont4, start8, abort8, cont8} = '0;
        vin4 = 0;
        vin8 = 0;
        #3;
        check("rst_dac4", dac_of(4), 0);
        check("rst_res4", res_of(4), 0);
        check("rst_busy4", busy_of(4), 0);
        check("rst_done4", done_of(4), 0);
        check("rst_sample8", sample_of(8), 0);
        check("rst_dac8", dac_of(8), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        conv(4, 11);
        conv(8, 0);
        conv(8, 255);
        settle = 3'd2;
        conv(4, 5);
        settle = 3'd0;

        for (int i = 0; i < 6; i++) begin
            settle = 3'($urandom_range(0, 3));
            conv(4, int'($urandom_range(0, 15)));
            conv(8, int'($urandom_range(0, 255)));
        end
        settle = 3'd0;

        // Continuous mode: 3 then 9, cont cleared during the second conversion.
        conv(4, 6);
        last4 = 6;
        vin4   = 3;
        cont4  = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n <= 12; n++) begin
            check("cont_done", done_of(4), (n == 5 || n == 10) ? 1 : 0);
            check("cont_busy", busy_of(4), (n < 10) ? 1 : 0);
            check("cont_result", res_of(4), (n < 5) ? last4 : (n < 10) ? 3 : 9);
            if (n == 5) begin
                vin4  = 9;
                cont4 = 1'b0;
            end
            @(negedge clk);
        end

        // Abort at the third decision edge with result 7 held.
        conv(4, 7);
        vin4   = 13;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        check("abort_busy", busy_of(4), 0);
        check("abort_done", done_of(4), 0);
        check("abort_result", res_of(4), 7);
        check("abort_dac", dac_of(4), 0);
        conv(4, 13);

        // start together with abort in IDLE is refused.
        start4 = 1'b1;
        abort4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        abort4 = 1'b0;
        check("start_abort_busy", busy_of(4), 0);
        check("start_abort_sample", sample_of(4), 0);
        @(negedge clk);

        // Asynchronous reset between edges in the middle of a conversion.
        vin4   = 10;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dac", dac_of(4), 0);
        check("async_rst_res", res_of(4), 0);
        check("async_rst_busy", busy_of(4), 0);
        check("async_rst_done", done_of(4), 0);
        check("async_rst_sample", sample_of(4), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        conv(4, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
